// File: rtl/quiz_round_ctrl.sv
// Round sequencer for the four-player quiz responder: arms the select stage,
// runs grab/answer countdowns, judges answers into saturating per-player scores.
// Optional build macro QUIZ_PENALTY_EN: wrong answers and answer timeouts cost a point.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for Host_Start, select stage frozen, Host_Clear live
// CLEAR   | one-cycle active-low clear of the select stage
// ARMED   | grab window running, presses allowed
// ANSWER  | winner latched, answer window running, host judges
// TIMEOUT | one-cycle grab-timeout beep, then back to IDLE
module quiz_round_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int GRAB_SEC   = 10,
  parameter int ANSWER_SEC = 15,
  parameter int SCORE_MAX  = 9
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Host_Start,
  input  logic        Host_Right,
  input  logic        Host_Wrong,
  input  logic        Host_Clear,
  input  logic        Win_Valid,
  input  logic [3:0]  Win_Player,
  output logic        Sel_RSTn,
  output logic        Sel_Start,
  output logic        TimeOver_Block,
  output logic [2:0]  Round_State,
  output logic [3:0]  Countdown,
  output logic [3:0]  Cur_Player,
  output logic [15:0] Scores,
  output logic        Timeout_Beep,
  output logic        Round_Done
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0] GRAB_LOAD   = 4'(GRAB_SEC);
  localparam logic [3:0] ANSWER_LOAD = 4'(ANSWER_SEC);
  localparam logic [3:0] SCORE_TOP   = 4'(SCORE_MAX);

`ifdef QUIZ_PENALTY_EN
  localparam bit PENALTY = 1'b1;
`else
  localparam bit PENALTY = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ARMED   = 3'd2,
    S_ANSWER  = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          win_ok;

  assign tick        = (tick_cnt == TICK_LAST);
  assign win_ok      = Win_Valid && (Win_Player != 4'd0) && (Win_Player <= 4'd4);
  assign Round_State = state;

  // Step one player's score up (saturating at SCORE_MAX) or down (saturating at 0).
  function automatic logic [15:0] score_step(input logic [15:0] s,
                                             input logic [3:0]  p,
                                             input logic        up);
    logic [15:0] r;
    logic [3:0]  v;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (p == 4'(i + 1)) begin
        v = s[i*4 +: 4];
        if (up) begin
          if (v < SCORE_TOP) v = v + 4'd1;
        end else begin
          if (v != 4'd0) v = v - 4'd1;
        end
        r[i*4 +: 4] = v;
      end
    end
    return r;
  endfunction

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state          <= S_IDLE;
      tick_cnt       <= '0;
      Sel_RSTn       <= 1'b0;
      Sel_Start      <= 1'b1;
      TimeOver_Block <= 1'b1;
      Countdown      <= 4'd0;
      Cur_Player     <= 4'd0;
      Scores         <= 16'd0;
      Timeout_Beep   <= 1'b0;
      Round_Done     <= 1'b0;
    end else begin
      Sel_RSTn     <= 1'b1;
      Timeout_Beep <= 1'b0;
      Round_Done   <= 1'b0;
      tick_cnt     <= tick ? '0 : tick_cnt + TW'(1);

      case (state)
        S_IDLE: begin
          Sel_Start      <= 1'b1;
          TimeOver_Block <= 1'b1;
          if (Host_Clear) Scores <= 16'd0;
          if (Host_Start) begin
            state      <= S_CLEAR;
            tick_cnt   <= '0;
            Sel_RSTn   <= 1'b0;
            Cur_Player <= 4'd0;
          end
        end

        S_CLEAR: begin
          state          <= S_ARMED;
          tick_cnt       <= '0;
          Sel_Start      <= 1'b0;
          TimeOver_Block <= 1'b0;
          Countdown      <= GRAB_LOAD;
        end

        S_ARMED: begin
          // A valid press wins over grab expiry on the same edge.
          if (win_ok) begin
            state          <= S_ANSWER;
            tick_cnt       <= '0;
            Cur_Player     <= Win_Player;
            Countdown      <= ANSWER_LOAD;
            TimeOver_Block <= 1'b1;
          end else if (tick) begin
            if (Countdown > 4'd1) begin
              Countdown <= Countdown - 4'd1;
            end else begin
              Countdown      <= 4'd0;
              state          <= S_TIMEOUT;
              tick_cnt       <= '0;
              Timeout_Beep   <= 1'b1;
              TimeOver_Block <= 1'b1;
              Sel_Start      <= 1'b1;
            end
          end
        end

        S_ANSWER: begin
          if (Host_Right && !Host_Wrong) begin
            Scores         <= score_step(Scores, Cur_Player, 1'b1);
            state          <= S_IDLE;
            tick_cnt       <= '0;
            Round_Done     <= 1'b1;
            Sel_Start      <= 1'b1;
          end else if (Host_Wrong && !Host_Right) begin
            if (PENALTY) Scores <= score_step(Scores, Cur_Player, 1'b0);
            state          <= S_IDLE;
            tick_cnt       <= '0;
            Round_Done     <= 1'b1;
            Sel_Start      <= 1'b1;
          end else if (tick) begin
            if (Countdown > 4'd1) begin
              Countdown <= Countdown - 4'd1;
            end else begin
              Countdown    <= 4'd0;
              if (PENALTY) Scores <= score_step(Scores, Cur_Player, 1'b0);
              Timeout_Beep <= 1'b1;
              state        <= S_IDLE;
              tick_cnt     <= '0;
              Round_Done   <= 1'b1;
              Sel_Start    <= 1'b1;
            end
          end
        end

        S_TIMEOUT: begin
          state          <= S_IDLE;
          tick_cnt       <= '0;
          Round_Done     <= 1'b1;
          Sel_Start      <= 1'b1;
          TimeOver_Block <= 1'b1;
        end

        default: begin
          state    <= S_IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Randomized bench for quiz_round_ctrl: rounds are predicted from cycle
// arithmetic (window = N*TICK_DIV cycles) and a four-entry score array.
module tb_quiz_round_ctrl;

  localparam int TD   = 4;
  localparam int GS   = 3;
  localparam int AS   = 5;
  localparam int SMAX = 9;

`ifdef QUIZ_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic        Host_Start = 1'b0, Host_Right = 1'b0, Host_Wrong = 1'b0, Host_Clear = 1'b0;
  logic        Win_Valid = 1'b0;
  logic [3:0]  Win_Player = 4'd0;
  logic        Sel_RSTn, Sel_Start, TimeOver_Block, Timeout_Beep, Round_Done;
  logic [2:0]  Round_State;
  logic [3:0]  Countdown, Cur_Player;
  logic [15:0] Scores;

  int total = 0;
  int bad   = 0;
  int sc[4];

  quiz_round_ctrl #(.TICK_DIV(TD), .GRAB_SEC(GS), .ANSWER_SEC(AS), .SCORE_MAX(SMAX)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .Host_Start(Host_Start), .Host_Right(Host_Right), .Host_Wrong(Host_Wrong),
    .Host_Clear(Host_Clear), .Win_Valid(Win_Valid), .Win_Player(Win_Player),
    .Sel_RSTn(Sel_RSTn), .Sel_Start(Sel_Start), .TimeOver_Block(TimeOver_Block),
    .Round_State(Round_State), .Countdown(Countdown), .Cur_Player(Cur_Player),
    .Scores(Scores), .Timeout_Beep(Timeout_Beep), .Round_Done(Round_Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_scores();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'(sc[i]);
    return r;
  endfunction

  function automatic logic [3:0] bad_player();
    int v;
    v = $urandom_range(0, 11);
    return (v == 0) ? 4'd0 : 4'(v + 4);
  endfunction

  // Runs one round starting just after a negedge in IDLE.
  // k: press cycle after ARMED entry (0 = none); pl: pressed player number;
  // jd: 0 none, 1 right, 2 wrong, 3 both; m: judgement cycle after ANSWER entry.
  task automatic do_round(input int k, input int pl, input int jd, input int m);
    bit pressed = 1'b0;
    bit done = 1'b0;
    Host_Start = 1'b1;
    @(negedge CLK);
    Host_Start = 1'b0;
    chk("clear_state", Round_State, 1);
    chk("clear_selrst", Sel_RSTn, 0);
    chk("clear_cur", Cur_Player, 0);
    @(negedge CLK);
    chk("armed_state", Round_State, 2);
    chk("armed_selrst", Sel_RSTn, 1);
    chk("armed_selstart", Sel_Start, 0);
    chk("armed_block", TimeOver_Block, 0);
    chk("armed_cd", Countdown, GS);

    for (int c = 1; c <= GS * TD; c++) begin
      if (c == k) begin
        Win_Valid = 1'b1; Win_Player = 4'(pl);
      end else if ($urandom_range(0, 3) == 0) begin
        Win_Valid = 1'b1; Win_Player = bad_player();
      end
      if ($urandom_range(0, 7) == 0) Host_Right = 1'b1;
      if ($urandom_range(0, 7) == 0) Host_Start = 1'b1;
      if ($urandom_range(0, 7) == 0) Host_Clear = 1'b1;
      @(negedge CLK);
      Win_Valid = 1'b0; Win_Player = 4'd0;
      Host_Right = 1'b0; Host_Start = 1'b0; Host_Clear = 1'b0;
      if (c == k && pl >= 1 && pl <= 4) begin
        chk("press_state", Round_State, 3);
        chk("press_cur", Cur_Player, pl);
        chk("press_cd", Countdown, AS);
        chk("press_beep", Timeout_Beep, 0);
        chk("press_block", TimeOver_Block, 1);
        pressed = 1'b1;
        break;
      end else if (c == GS * TD) begin
        chk("gto_state", Round_State, 4);
        chk("gto_beep", Timeout_Beep, 1);
        chk("gto_cd", Countdown, 0);
        chk("gto_cur", Cur_Player, 0);
        chk("gto_block", TimeOver_Block, 1);
      end else begin
        chk("armed_hold", Round_State, 2);
        chk("armed_tick_cd", Countdown, GS - c / TD);
      end
    end

    if (!pressed) begin
      @(negedge CLK);
      chk("gto_idle", Round_State, 0);
      chk("gto_done", Round_Done, 1);
      chk("gto_beep_off", Timeout_Beep, 0);
      chk("gto_scores", Scores, model_scores());
    end else begin
      for (int c = 1; c <= AS * TD && !done; c++) begin
        if (c == m) begin
          Host_Right = jd[0]; Host_Wrong = jd[1];
        end
        if ($urandom_range(0, 5) == 0) begin
          Win_Valid = 1'b1; Win_Player = 4'($urandom_range(1, 4));
        end
        if ($urandom_range(0, 7) == 0) Host_Start = 1'b1;
        if ($urandom_range(0, 7) == 0) Host_Clear = 1'b1;
        @(negedge CLK);
        Host_Right = 1'b0; Host_Wrong = 1'b0; Win_Valid = 1'b0; Win_Player = 4'd0;
        Host_Start = 1'b0; Host_Clear = 1'b0;
        if (c == m && (jd == 1 || jd == 2)) begin
          if (jd == 1) sc[pl-1] = (sc[pl-1] < SMAX) ? sc[pl-1] + 1 : SMAX;
          else if (PEN && sc[pl-1] > 0) sc[pl-1] = sc[pl-1] - 1;
          chk("judge_idle", Round_State, 0);
          chk("judge_done", Round_Done, 1);
          chk("judge_beep", Timeout_Beep, 0);
          chk("judge_scores", Scores, model_scores());
          done = 1'b1;
        end else if (c == AS * TD) begin
          if (PEN && sc[pl-1] > 0) sc[pl-1] = sc[pl-1] - 1;
          chk("ato_idle", Round_State, 0);
          chk("ato_done", Round_Done, 1);
          chk("ato_beep", Timeout_Beep, 1);
          chk("ato_scores", Scores, model_scores());
          done = 1'b1;
        end else begin
          chk("answer_hold", Round_State, 3);
          chk("answer_cd", Countdown, AS - c / TD);
          chk("answer_scores", Scores, model_scores());
        end
      end
    end

    @(negedge CLK);
    chk("end_done_off", Round_Done, 0);
    chk("end_beep_off", Timeout_Beep, 0);
    chk("end_state", Round_State, 0);
    chk("end_selstart", Sel_Start, 1);
    chk("end_block", TimeOver_Block, 1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) sc[i] = 0;
    #1 RSTn = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_state", Round_State, 0);
    chk("rst_selrst", Sel_RSTn, 0);
    chk("rst_selstart", Sel_Start, 1);
    chk("rst_block", TimeOver_Block, 1);
    chk("rst_cd", Countdown, 0);
    chk("rst_cur", Cur_Player, 0);
    chk("rst_scores", Scores, 0);
    chk("rst_beep", Timeout_Beep, 0);
    chk("rst_done", Round_Done, 0);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("rst_selrst_rise", Sel_RSTn, 1);
    chk("rst_idle", Round_State, 0);

    do_round(2, 2, 1, 1);
    chk("right_scores_abs", Scores, 16'h0010);
    do_round(0, 0, 0, 0);
    do_round(GS * TD, 3, 1, 2);
    do_round(5, 0, 0, 0);
    do_round(3, 5, 0, 0);
    do_round(1, 4, 3, 2);
    do_round(1, 4, 3, AS * TD);

    Host_Right = 1'b1;
    @(negedge CLK);
    Host_Right = 1'b0;
    chk("idle_right_state", Round_State, 0);
    chk("idle_right_scores", Scores, model_scores());

    Host_Clear = 1'b1;
    @(negedge CLK);
    Host_Clear = 1'b0;
    for (int i = 0; i < 4; i++) sc[i] = 0;
    chk("clear_scores", Scores, model_scores());

    for (int i = 0; i < SMAX; i++) do_round(1, 1, 1, 1);
    chk("sat_at_max", Scores[3:0], SMAX);
    do_round(1, 1, 1, 1);
    chk("sat_hold", Scores[3:0], SMAX);
    do_round(1, 1, 2, 1);
    chk("wrong_rule", Scores[3:0], PEN ? SMAX - 1 : SMAX);

    for (int r = 0; r < 40; r++) begin
      int k, pl;
      k  = $urandom_range(0, GS * TD + 1);
      pl = ($urandom_range(0, 3) == 0) ? int'(bad_player()) : int'($urandom_range(1, 4));
      do_round(k, pl, int'($urandom_range(0, 3)), int'($urandom_range(1, AS * TD + 2)));
    end

    Host_Start = 1'b1;
    @(negedge CLK);
    Host_Start = 1'b0;
    @(negedge CLK);
    Win_Valid = 1'b1; Win_Player = 4'd1;
    @(negedge CLK);
    Win_Valid = 1'b0; Win_Player = 4'd0;
    chk("mid_answer", Round_State, 3);
    #2 RSTn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) sc[i] = 0;
    chk("mid_state", Round_State, 0);
    chk("mid_selrst", Sel_RSTn, 0);
    chk("mid_selstart", Sel_Start, 1);
    chk("mid_block", TimeOver_Block, 1);
    chk("mid_cd", Countdown, 0);
    chk("mid_cur", Cur_Player, 0);
    chk("mid_scores", Scores, model_scores());
    chk("mid_beep", Timeout_Beep, 0);
    chk("mid_done", Round_Done, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("mid_selrst_rise", Sel_RSTn, 1);
    do_round(2, 3, 1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
